// File: rtl/axis_flit_deserializer.sv
// Reassembles SERIALIZATION_FACTOR narrow flits into one AXI-Stream word.
// The first flit lands in the least-significant slice. A word finishes on its
// last flit, or earlier if tlast arrives first; in that case the unwritten
// upper slices are zeroed and err_short_word is set.
module axis_flit_deserializer #(
    parameter int unsigned TDATA_WIDTH          = 32,
    parameter int unsigned TDEST_WIDTH          = 4,
    parameter int unsigned SERIALIZATION_FACTOR = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flit_in_tvalid,
    output logic                                          flit_in_tready,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]   flit_in_tdata,
    input  logic [TDEST_WIDTH-1:0]                        flit_in_tdest,
    input  logic                                          flit_in_tlast,
    output logic                                          axis_out_tvalid,
    input  logic                                          axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                        axis_out_tdata,
    output logic [TDEST_WIDTH-1:0]                        axis_out_tdest,
    output logic                                          axis_out_tlast,
    output logic                                          err_tdest_mismatch,
    output logic                                          err_short_word,
    output logic [15:0]                                   word_count
);

    localparam int unsigned FLITW = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int unsigned IDXW  = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SERIALIZATION_FACTOR - 1);

    // Reject parameter sets where the word does not split into whole flits.
    if (FLITW * SERIALIZATION_FACTOR != TDATA_WIDTH) begin : g_bad_params
        $error("TDATA_WIDTH must be a multiple of SERIALIZATION_FACTOR");
    end

    logic [IDXW-1:0]        idx;
    logic [TDATA_WIDTH-1:0] asm_data;
    logic [TDEST_WIDTH-1:0] asm_tdest;

    logic                   flit_accept_c;
    logic                   idx_last_c;
    logic                   word_done_c;
    logic [TDATA_WIDTH-1:0] word_c;
    logic [TDEST_WIDTH-1:0] word_tdest_c;

    // Input may advance whenever the output slot is empty or draining this cycle.
    assign flit_in_tready = !axis_out_tvalid || axis_out_tready;

    assign flit_accept_c = flit_in_tvalid && flit_in_tready;
    assign idx_last_c    = (idx == LAST_IDX);
    assign word_done_c   = flit_accept_c && (idx_last_c || flit_in_tlast);
    assign word_tdest_c  = (idx == '0) ? flit_in_tdest : asm_tdest;

    // Merge the incoming flit into its slice; slices above it read as zero.
    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < SERIALIZATION_FACTOR; k++) begin
            if (IDXW'(k) < idx) begin
                word_c[k*FLITW +: FLITW] = asm_data[k*FLITW +: FLITW];
            end else if (IDXW'(k) == idx) begin
                word_c[k*FLITW +: FLITW] = flit_in_tdata;
            end
        end
    end

    // Flit index and partial-word assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            asm_data  <= '0;
            asm_tdest <= '0;
        end else if (flit_accept_c) begin
            asm_data <= word_c;
            if (idx == '0) begin
                asm_tdest <= flit_in_tdest;
            end
            if (word_done_c) begin
                idx <= '0;
            end else begin
                idx <= idx + IDXW'(1);
            end
        end
    end

    // Output slot: load on completion (even while draining), else clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tdest  <= '0;
            axis_out_tlast  <= 1'b0;
        end else if (word_done_c) begin
            axis_out_tvalid <= 1'b1;
            axis_out_tdata  <= word_c;
            axis_out_tdest  <= word_tdest_c;
            axis_out_tlast  <= flit_in_tlast;
        end else if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
        end
    end

    // Sticky protocol error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_tdest_mismatch <= 1'b0;
            err_short_word     <= 1'b0;
        end else begin
            if (flit_accept_c && (idx != '0) && (flit_in_tdest != asm_tdest)) begin
                err_tdest_mismatch <= 1'b1;
            end
            if (word_done_c && !idx_last_c) begin
                err_short_word <= 1'b1;
            end
        end
    end

    // Count delivered words, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count <= '0;
        end else if (axis_out_tvalid && axis_out_tready) begin
            word_count <= word_count + 16'd1;
        end
    end

endmodule
